// File: rtl/seq_lock.sv
// seq_lock: parametrised sequential combination lock.
// Digits arrive on value/new_digit; a full correct code opens the lock,
// repeated failures trigger a timed lockout, and the code can be
// reprogrammed while open.
module seq_lock #(
    parameter int DIGIT_W        = 4,
    parameter int CODE_LEN       = 3,
    parameter int MAX_FAIL       = 3,
    parameter int LOCKOUT_CYCLES = 16,
    localparam int IDX_W  = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1,
    localparam int PROG_W = $clog2(CODE_LEN + 1),
    localparam int FAIL_W = $clog2(MAX_FAIL + 1)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [DIGIT_W-1:0] value,
    input  logic               new_digit,
    input  logic               relock,
    input  logic               code_we,
    input  logic [IDX_W-1:0]   code_idx,
    input  logic [DIGIT_W-1:0] code_data,
    output logic               opened,
    output logic               locked_out,
    output logic [PROG_W-1:0]  progress,
    output logic [FAIL_W-1:0]  fail_count
);

    localparam int TMR_W = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [PROG_W-1:0] LAST_POS   = PROG_W'(CODE_LEN - 1);
    localparam logic [FAIL_W-1:0] FAIL_LIMIT = FAIL_W'(MAX_FAIL);
    localparam logic [IDX_W:0]    CODE_LEN_X = (IDX_W + 1)'(CODE_LEN);
    localparam logic [TMR_W-1:0]  TMR_LOAD   = TMR_W'(LOCKOUT_CYCLES);
    localparam logic [TMR_W-1:0]  TMR_LAST   = TMR_W'(1);

    typedef enum logic [1:0] {
        ST_ENTRY,
        ST_OPEN,
        ST_LOCKOUT
    } state_t;

    state_t             state;
    logic [DIGIT_W-1:0] code [CODE_LEN];
    logic [TMR_W-1:0]   timer;

    logic               digit_ok;
    logic               code_idx_ok;
    logic [FAIL_W-1:0]  fail_inc;

    // Digit comparison against the expected position, saturating fail increment
    always_comb begin
        digit_ok    = (value == code[progress[IDX_W-1:0]]);
        code_idx_ok = ({1'b0, code_idx} < CODE_LEN_X);
        fail_inc    = (fail_count == FAIL_LIMIT) ? fail_count : fail_count + 1'b1;
    end

    // Lock state machine, code storage and lockout timer with registered outputs
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= ST_ENTRY;
            progress   <= '0;
            fail_count <= '0;
            opened     <= 1'b0;
            locked_out <= 1'b0;
            timer      <= '0;
            for (int unsigned i = 0; i < CODE_LEN; i++) begin
                code[i] <= DIGIT_W'(i + 1);
            end
        end else begin
            case (state)
                ST_ENTRY: begin
                    if (new_digit) begin
                        if (digit_ok) begin
                            if (progress == LAST_POS) begin
                                state      <= ST_OPEN;
                                opened     <= 1'b1;
                                progress   <= '0;
                                fail_count <= '0;
                            end else begin
                                progress <= progress + 1'b1;
                            end
                        end else begin
                            progress   <= '0;
                            fail_count <= fail_inc;
                            if (fail_inc == FAIL_LIMIT) begin
                                state      <= ST_LOCKOUT;
                                locked_out <= 1'b1;
                                timer      <= TMR_LOAD;
                            end
                        end
                    end
                end

                ST_OPEN: begin
                    if (code_we && code_idx_ok) begin
                        code[code_idx] <= code_data;
                    end
                    if (relock) begin
                        state    <= ST_ENTRY;
                        opened   <= 1'b0;
                        progress <= '0;
                    end
                end

                ST_LOCKOUT: begin
                    if (timer == TMR_LAST) begin
                        state      <= ST_ENTRY;
                        locked_out <= 1'b0;
                        fail_count <= '0;
                        timer      <= '0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                default: begin
                    state      <= ST_ENTRY;
                    opened     <= 1'b0;
                    locked_out <= 1'b0;
                    progress   <= '0;
                end
            endcase
        end
    end

endmodule
